// File: rtl/rf_arb_pkg.sv
// ---------------------------------------------------------------------------
// rf_arb_pkg
// Shared constants and types for the register-file write arbiter.
//   XLEN          - architectural data width
//   ADDR_W        - register address width
//   NUM_ARCH_REGS - number of architectural registers (x0 hardwired to zero)
//   reg_addr_t    - register address type
//   xlen_t        - data word type
// ---------------------------------------------------------------------------
package rf_arb_pkg;
    localparam int XLEN          = 32;
    localparam int ADDR_W        = 5;
    localparam int NUM_ARCH_REGS = 32;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]   xlen_t;
endpackage

// File: rtl/rf_write_arbiter_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Scans the request vector starting at
// i_ptr, wrapping at NUM_REQ, and grants the first active requester.
// Ports:
//   i_req   [NUM_REQ-1:0] request vector
//   i_ptr   [PTR_W-1:0]   index with highest priority this cycle
//   o_grant [NUM_REQ-1:0] one-hot grant (zero when no request)
//   o_idx   [PTR_W-1:0]   index of the granted requester
//   o_valid               a grant was issued
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int NUM_REQ = 3,
    localparam int PTR_W  = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [PTR_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [PTR_W-1:0]   o_idx,
    output logic               o_valid
);
    import rf_arb_pkg::*;

    // One extra bit so ptr+k never overflows before the wrap compare; a
    // single subtraction is enough because ptr+k < 2*NUM_REQ.
    logic [PTR_W:0] w_cand;

    always_comb begin
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        w_cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = {1'b0, i_ptr} + (PTR_W+1)'(k);
            if (w_cand >= (PTR_W+1)'(NUM_REQ)) begin
                w_cand = w_cand - (PTR_W+1)'(NUM_REQ);
            end
            if (!o_valid && i_req[w_cand[PTR_W-1:0]]) begin
                o_valid                     = 1'b1;
                o_idx                       = w_cand[PTR_W-1:0];
                o_grant[w_cand[PTR_W-1:0]] = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
// Shares the single register-file write port among NUM_REQ writeback
// requesters with round-robin arbitration and a one-cycle registered write
// stage, keeps a per-register busy scoreboard for decode, and forwards the
// register-file read data to decode.
// Optional feature macro: RF_WRITE_BYPASS_EN
//   defined   - read data is bypassed from the write stage on address match
//   undefined - read data comes straight from the register file
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   req_valid/req_ready        per-requester handshake (ready is one-hot or 0)
//   req_addr/req_data          packed per-requester destination and data
//   issue_valid/issue_addr     decode reserves a destination register
//   issue_stall                reservation refused (destination already busy)
//   rf_we/rf_addr/rf_wdata     register-file write port (WE3/A3/WD3)
//   rd_addr1/2, rf_rdata1/2    read addresses and register-file read data
//   rd_data1/2                 read data to decode
//   busy                       scoreboard vector, bit 0 always 0
// ---------------------------------------------------------------------------
module rf_write_arbiter #(
    parameter int NUM_REQ = 3,
    parameter int XLEN    = rf_arb_pkg::XLEN,
    parameter int ADDR_W  = rf_arb_pkg::ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*XLEN-1:0]   req_data,
    input  logic                      issue_valid,
    input  logic [ADDR_W-1:0]         issue_addr,
    output logic                      issue_stall,
    output logic                      rf_we,
    output logic [ADDR_W-1:0]         rf_addr,
    output logic [XLEN-1:0]           rf_wdata,
    input  logic [ADDR_W-1:0]         rd_addr1,
    input  logic [ADDR_W-1:0]         rd_addr2,
    input  logic [XLEN-1:0]           rf_rdata1,
    input  logic [XLEN-1:0]           rf_rdata2,
    output logic [XLEN-1:0]           rd_data1,
    output logic [XLEN-1:0]           rd_data2,
    output logic [2**ADDR_W-1:0]      busy
);
    import rf_arb_pkg::*;

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int NREGS = 2**ADDR_W;

    logic [PTR_W-1:0]   r_ptr;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [XLEN-1:0]    r_wdata;
    logic [NREGS-1:0]   r_busy;

    logic [NUM_REQ-1:0] w_req;
    logic [NUM_REQ-1:0] w_grant;
    logic [PTR_W-1:0]   w_idx;
    logic               w_any;
    logic [PTR_W-1:0]   w_ptr_nxt;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [XLEN-1:0]    w_sel_data;
    logic [NREGS-1:0]   w_busy_nxt;

    // No acceptance is reported while reset is held.
    assign w_req = req_valid & {NUM_REQ{rst}};

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_rr (
        .i_req   (w_req),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_valid (w_any)
    );

    assign req_ready = w_grant;

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_idx == PTR_W'(i)) begin
                w_sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_data = req_data[i*XLEN +: XLEN];
            end
        end
    end

    // Explicit wrap: NUM_REQ need not be a power of two.
    assign w_ptr_nxt = (w_idx == PTR_W'(NUM_REQ-1)) ? '0 : w_idx + PTR_W'(1);

    assign issue_stall = issue_valid && r_busy[issue_addr];

    // Clear first, then set, so a same-cycle commit and reservation of one
    // register leaves it busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (r_we && (r_addr != '0)) begin
            w_busy_nxt[r_addr] = 1'b0;
        end
        if (issue_valid && !issue_stall && (issue_addr != '0)) begin
            w_busy_nxt[issue_addr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_busy  <= '0;
        end else begin
            if (w_any) begin
                r_ptr   <= w_ptr_nxt;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_data;
            end
            // Writes to x0 are accepted but never reach the register file.
            r_we   <= w_any && (w_sel_addr != '0);
            r_busy <= w_busy_nxt;
        end
    end

    assign rf_we    = r_we;
    assign rf_addr  = r_addr;
    assign rf_wdata = r_wdata;
    assign busy     = r_busy;

`ifdef RF_WRITE_BYPASS_EN
    // Write-through: a read of the register being written sees the new value.
    assign rd_data1 = (r_we && (r_addr == rd_addr1) && (rd_addr1 != '0)) ? r_wdata : rf_rdata1;
    assign rd_data2 = (r_we && (r_addr == rd_addr2) && (rd_addr2 != '0)) ? r_wdata : rf_rdata2;
`else
    assign rd_data1 = rf_rdata1;
    assign rd_data2 = rf_rdata2;
`endif

endmodule

// File: tb/tb_rf_write_arbiter.sv
module tb_rf_write_arbiter;
    import rf_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic [14:0] req_addr;
    logic [95:0] req_data;
    logic        issue_valid;
    reg_addr_t   issue_addr;
    logic        issue_stall;
    logic        rf_we;
    reg_addr_t   rf_addr;
    xlen_t       rf_wdata;
    reg_addr_t   rd_addr1;
    reg_addr_t   rd_addr2;
    xlen_t       rf_rdata1;
    xlen_t       rf_rdata2;
    xlen_t       rd_data1;
    xlen_t       rd_data2;
    logic [31:0] busy;

    int errors = 0;
    int checks = 0;

`ifdef RF_WRITE_BYPASS_EN
    localparam logic [31:0] EXP_BYP = 32'h0000_1234;
`else
    localparam logic [31:0] EXP_BYP = 32'h0000_BEEF;
`endif

    rf_write_arbiter #(
        .NUM_REQ (3),
        .XLEN    (32),
        .ADDR_W  (5)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .issue_stall (issue_stall),
        .rf_we       (rf_we),
        .rf_addr     (rf_addr),
        .rf_wdata    (rf_wdata),
        .rd_addr1    (rd_addr1),
        .rd_addr2    (rd_addr2),
        .rf_rdata1   (rf_rdata1),
        .rf_rdata2   (rf_rdata2),
        .rd_data1    (rd_data1),
        .rd_data2    (rd_data2),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file model: x9 starts at 0xBEEF, x0 reads zero.
    logic [31:0] regs [32];
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
            regs[9] <= 32'h0000_BEEF;
        end else if (rf_we && rf_addr != 5'd0) begin
            regs[rf_addr] <= rf_wdata;
        end
    end
    assign rf_rdata1 = (rd_addr1 == 5'd0) ? 32'h0 : regs[rd_addr1];
    assign rf_rdata2 = (rd_addr2 == 5'd0) ? 32'h0 : regs[rd_addr2];

    typedef struct {
        logic [2:0]  rv;
        logic [4:0]  a0, a1, a2;
        logic [31:0] d0, d1, d2;
        logic [2:0]  rdy;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive_req(input logic [2:0] rv, input logic [4:0] a0, input logic [4:0] a1,
                             input logic [4:0] a2, input logic [31:0] d0, input logic [31:0] d1,
                             input logic [31:0] d2);
        req_valid = rv;
        req_addr  = {a2, a1, a0};
        req_data  = {d2, d1, d0};
    endtask

    initial begin
        rst = 1'b0;
        issue_valid = 1'b0;
        issue_addr = '0;
        rd_addr1 = '0;
        rd_addr2 = '0;
        drive_req(3'b111, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h3);

        // Arbitration sequence from reset (ptr=0).
        vecs[0]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'h11111111, 32'h22222222, 32'h33333333, 3'b001, 1'b0, 5'd0, 32'h0};
        vecs[1]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'h11111111, 32'h22222222, 32'h33333333, 3'b010, 1'b1, 5'd1, 32'h11111111};
        vecs[2]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'h11111111, 32'h22222222, 32'h33333333, 3'b100, 1'b1, 5'd2, 32'h22222222};
        vecs[3]  = '{3'b111, 5'd1, 5'd2, 5'd3, 32'h11111111, 32'h22222222, 32'h33333333, 3'b001, 1'b1, 5'd3, 32'h33333333};
        vecs[4]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b1, 5'd1, 32'h11111111};
        vecs[5]  = '{3'b010, 5'd0, 5'd0, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0, 3'b010, 1'b0, 5'd0, 32'h0};
        vecs[6]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 5'd0, 32'h0};
        vecs[7]  = '{3'b011, 5'd4, 5'd6, 5'd0, 32'h44444444, 32'h66666666, 32'h0, 3'b001, 1'b0, 5'd0, 32'h0};
        vecs[8]  = '{3'b010, 5'd4, 5'd6, 5'd0, 32'h44444444, 32'h66666666, 32'h0, 3'b010, 1'b1, 5'd4, 32'h44444444};
        vecs[9]  = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b1, 5'd6, 32'h66666666};
        vecs[10] = '{3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 5'd0, 32'h0};

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_we", 64'(rf_we), 64'd0);
        chk("rst_addr", 64'(rf_addr), 64'd0);
        chk("rst_wdata", 64'(rf_wdata), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        drive_req(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);

        // Table: round-robin order, x0 drop, wrap with partial requests
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            drive_req(vecs[i].rv, vecs[i].a0, vecs[i].a1, vecs[i].a2, vecs[i].d0, vecs[i].d1, vecs[i].d2);
            #1;
            chk($sformatf("vec%0d_ready", i), 64'(req_ready), 64'(vecs[i].rdy));
            chk($sformatf("vec%0d_we", i), 64'(rf_we), 64'(vecs[i].we));
            if (vecs[i].we) begin
                chk($sformatf("vec%0d_addr", i), 64'(rf_addr), 64'(vecs[i].wa));
                chk($sformatf("vec%0d_wdata", i), 64'(rf_wdata), 64'(vecs[i].wd));
            end
        end
        rd_addr1 = 5'd0;
        #1;
        chk("x0_read", 64'(rd_data1), 64'd0);

        // Scoreboard: reserve x5, second reservation stalls, commit clears
        @(negedge clk);
        issue_valid = 1'b1; issue_addr = 5'd5;
        #1;
        chk("iss5_stall0", 64'(issue_stall), 64'd0);
        @(negedge clk);
        #1;
        chk("iss5_busy", 64'(busy[5]), 64'd1);
        chk("iss5_stall1", 64'(issue_stall), 64'd1);
        @(negedge clk);
        issue_valid = 1'b0;
        drive_req(3'b001, 5'd5, 5'd0, 5'd0, 32'h55, 32'h0, 32'h0);
        #1;
        chk("w5_ready", 64'(req_ready), 64'b001);
        @(negedge clk);
        drive_req(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        #1;
        chk("w5_we", 64'(rf_we), 64'd1);
        chk("w5_addr", 64'(rf_addr), 64'd5);
        chk("w5_busy_hold", 64'(busy[5]), 64'd1);
        @(negedge clk);
        issue_valid = 1'b1; issue_addr = 5'd5;
        #1;
        chk("w5_busy_clr", 64'(busy[5]), 64'd0);
        chk("w5_stall", 64'(issue_stall), 64'd0);

        // Same-cycle commit and reservation of x7: set wins
        @(negedge clk);
        issue_valid = 1'b0;
        drive_req(3'b010, 5'd0, 5'd7, 5'd0, 32'h0, 32'h77, 32'h0);
        #1;
        chk("w7_ready", 64'(req_ready), 64'b010);
        @(negedge clk);
        drive_req(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        issue_valid = 1'b1; issue_addr = 5'd7;
        #1;
        chk("w7_we", 64'(rf_we), 64'd1);
        chk("w7_addr", 64'(rf_addr), 64'd7);
        chk("w7_stall", 64'(issue_stall), 64'd0);
        @(negedge clk);
        issue_valid = 1'b0;
        #1;
        chk("w7_busy_set", 64'(busy[7]), 64'd1);

        // Read during write of x9
        @(negedge clk);
        rd_addr1 = 5'd9; rd_addr2 = 5'd0;
        drive_req(3'b100, 5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h1234);
        #1;
        chk("w9_ready", 64'(req_ready), 64'b100);
        chk("w9_rd_old", 64'(rd_data1), 64'h0000BEEF);
        chk("x0_rd2", 64'(rd_data2), 64'd0);
        @(negedge clk);
        drive_req(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        #1;
        chk("w9_we", 64'(rf_we), 64'd1);
        chk("w9_rd_same", 64'(rd_data1), 64'(EXP_BYP));
        @(negedge clk);
        #1;
        chk("w9_rd_next", 64'(rd_data1), 64'h00001234);
        chk("w9_we_off", 64'(rf_we), 64'd0);

        // Reset while a write is in flight
        @(negedge clk);
        rd_addr1 = 5'd10;
        drive_req(3'b001, 5'd10, 5'd0, 5'd0, 32'hABCD, 32'h0, 32'h0);
        #1;
        chk("w10_ready", 64'(req_ready), 64'b001);
        @(negedge clk);
        drive_req(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        #1;
        chk("w10_inflight", 64'(rf_we), 64'd1);
        chk("w10_busy7", 64'(busy[7]), 64'd1);
        drive_req(3'b111, 5'd11, 5'd12, 5'd13, 32'hB1, 32'hB2, 32'hB3);
        rst = 1'b0;
        #1;
        chk("mrst_we", 64'(rf_we), 64'd0);
        chk("mrst_addr", 64'(rf_addr), 64'd0);
        chk("mrst_wdata", 64'(rf_wdata), 64'd0);
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_ready", 64'(req_ready), 64'd0);
        @(negedge clk);
        #1;
        chk("mrst_we_next", 64'(rf_we), 64'd0);
        chk("mrst_x10", 64'(rd_data1), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("post_rst_ptr", 64'(req_ready), 64'b001);
        @(negedge clk);
        drive_req(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0);
        #1;
        chk("post_rst_we", 64'(rf_we), 64'd1);
        chk("post_rst_addr", 64'(rf_addr), 64'd11);
        chk("post_rst_wdata", 64'(rf_wdata), 64'hB1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
